// File: rtl/rom_uart_loader.sv
// Boot loader: parses SYNC/CNT/ADR/DATA/CSUM frames from a UART byte stream into program-ROM writes.
// Latency: rom_we_o one cycle after the DAT_HI byte; the reply strobe one cycle after CSUM (or after a timeout) when the transmitter is idle.
// Backpressure: none on rx (one byte per strobe); the reply is held in REPLY while tx_busy_i is high.
module rom_uart_loader #(
    parameter int          ADDR_WIDTH     = 13,
    parameter int          DATA_WIDTH     = 14,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [7:0]            rx_dat_i,
    input  logic                  rx_stb_i,
    output logic [7:0]            tx_dat_o,
    output logic                  tx_stb_o,
    input  logic                  tx_busy_i,
    output logic [ADDR_WIDTH-1:0] rom_adr_o,
    output logic [DATA_WIDTH-1:0] rom_dat_o,
    output logic                  rom_we_o,
    output logic                  cpu_reset_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_ADR_LO,
        S_ADR_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_CSUM,
        S_REPLY
    } state_t;

    state_t                  state_q,     state_d;
    logic [7:0]              lo_q,        lo_d;
    logic [15:0]             words_q,     words_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [7:0]              sum_q,       sum_d;
    logic [TW-1:0]           tmo_q,       tmo_d;
    logic                    rom_we_q,    rom_we_d;
    logic [ADDR_WIDTH-1:0]   rom_adr_q,   rom_adr_d;
    logic [DATA_WIDTH-1:0]   rom_dat_q,   rom_dat_d;
    logic [7:0]              tx_dat_q,    tx_dat_d;
    logic                    release_q,   release_d;
    logic                    cpu_reset_q, cpu_reset_d;
    logic                    err_q,       err_d;

    logic [7:0]              sum_nxt;
    logic                    in_frame;
    logic                    tmo_fire;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            words_q     <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            rom_we_q    <= 1'b0;
            rom_adr_q   <= '0;
            rom_dat_q   <= '0;
            tx_dat_q    <= '0;
            release_q   <= 1'b0;
            cpu_reset_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            words_q     <= words_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            rom_we_q    <= rom_we_d;
            rom_adr_q   <= rom_adr_d;
            rom_dat_q   <= rom_dat_d;
            tx_dat_q    <= tx_dat_d;
            release_q   <= release_d;
            cpu_reset_q <= cpu_reset_d;
            err_q       <= err_d;
        end
    end

    // Idle-gap watchdog: a byte arriving on the terminal cycle still counts.
    always_comb begin
        in_frame = (state_q != S_IDLE) && (state_q != S_REPLY);
        tmo_fire = 1'b0;
        tmo_d    = '0;
        if (in_frame && !rx_stb_i) begin
            if (tmo_q == TMO_LAST) begin
                tmo_fire = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        words_d     = words_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        rom_we_d    = 1'b0;
        rom_adr_d   = rom_adr_q;
        rom_dat_d   = rom_dat_q;
        tx_dat_d    = tx_dat_q;
        release_d   = release_q;
        cpu_reset_d = cpu_reset_q;
        err_d       = err_q;
        sum_nxt     = sum_q + rx_dat_i;

        case (state_q)
            S_IDLE: begin
                if (rx_stb_i && rx_dat_i == SYNC_BYTE) begin
                    state_d     = S_CNT_LO;
                    cpu_reset_d = 1'b1;
                    err_d       = 1'b0;
                    sum_d       = '0;
                end
            end
            S_CNT_LO: begin
                if (rx_stb_i) begin
                    lo_d    = rx_dat_i;
                    sum_d   = sum_nxt;
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (rx_stb_i) begin
                    words_d = {rx_dat_i, lo_q};
                    sum_d   = sum_nxt;
                    state_d = S_ADR_LO;
                end
            end
            S_ADR_LO: begin
                if (rx_stb_i) begin
                    lo_d    = rx_dat_i;
                    sum_d   = sum_nxt;
                    state_d = S_ADR_HI;
                end
            end
            S_ADR_HI: begin
                if (rx_stb_i) begin
                    addr_d  = ADDR_WIDTH'({rx_dat_i, lo_q});
                    sum_d   = sum_nxt;
                    state_d = (words_q == 16'd0) ? S_CSUM : S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                if (rx_stb_i) begin
                    lo_d    = rx_dat_i;
                    sum_d   = sum_nxt;
                    state_d = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (rx_stb_i) begin
                    rom_we_d  = 1'b1;
                    rom_adr_d = addr_q;
                    rom_dat_d = DATA_WIDTH'({rx_dat_i, lo_q});
                    addr_d    = addr_q + 1'b1;
                    words_d   = words_q - 16'd1;
                    sum_d     = sum_nxt;
                    state_d   = (words_q == 16'd1) ? S_CSUM : S_DAT_LO;
                end
            end
            S_CSUM: begin
                if (rx_stb_i) begin
                    sum_d   = sum_nxt;
                    state_d = S_REPLY;
                    if (sum_nxt == 8'd0) begin
                        tx_dat_d  = ACK_BYTE;
                        release_d = 1'b1;
                    end else begin
                        tx_dat_d  = NAK_BYTE;
                        release_d = 1'b0;
                        err_d     = 1'b1;
                    end
                end
            end
            S_REPLY: begin
                if (!tx_busy_i) begin
                    state_d   = S_IDLE;
                    release_d = 1'b0;
                    if (release_q) begin
                        cpu_reset_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo_fire) begin
            state_d   = S_REPLY;
            tx_dat_d  = NAK_BYTE;
            release_d = 1'b0;
            err_d     = 1'b1;
        end
    end

    // The CPU is released in the very cycle the ACK strobe leaves.
    assign tx_stb_o    = (state_q == S_REPLY) && !tx_busy_i;
    assign cpu_reset_o = cpu_reset_q && !(tx_stb_o && release_q);
    assign tx_dat_o    = tx_dat_q;
    assign rom_we_o    = rom_we_q;
    assign rom_adr_o   = rom_adr_q;
    assign rom_dat_o   = rom_dat_q;
    assign busy_o      = (state_q != S_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed frames against a frame-level model of expected ROM writes, replies and status flags.
module tb_rom_uart_loader;

    localparam int T = 40;

    logic        clk_i     = 1'b0;
    logic        reset_i   = 1'b1;
    logic [7:0]  rx_dat_i  = 8'h00;
    logic        rx_stb_i  = 1'b0;
    logic        tx_busy_i = 1'b0;
    logic [7:0]  tx_dat_o;
    logic        tx_stb_o;
    logic [12:0] rom_adr_o;
    logic [13:0] rom_dat_o;
    logic        rom_we_o;
    logic        cpu_reset_o;
    logic        busy_o;
    logic        err_o;

    rom_uart_loader #(
        .ADDR_WIDTH     (13),
        .DATA_WIDTH     (14),
        .SYNC_BYTE      (8'hA5),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rx_dat_i    (rx_dat_i),
        .rx_stb_i    (rx_stb_i),
        .tx_dat_o    (tx_dat_o),
        .tx_stb_o    (tx_stb_o),
        .tx_busy_i   (tx_busy_i),
        .rom_adr_o   (rom_adr_o),
        .rom_dat_o   (rom_dat_o),
        .rom_we_o    (rom_we_o),
        .cpu_reset_o (cpu_reset_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [12:0] adr;
        logic [13:0] dat;
    } wr_t;
    typedef struct {
        int         due;
        logic [7:0] dat;
    } tx_t;

    wr_t         wq[$];
    tx_t         tq[$];
    logic [12:0] log_adr[$];
    logic [13:0] log_dat[$];
    logic [7:0]  log_tx[$];
    logic [7:0]  fq[$];
    logic        exp_cpu  = 1'b0;
    logic        exp_err  = 1'b0;
    logic        exp_busy = 1'b0;
    int          gap_at   = -1;
    int          gap_len  = 0;
    int          n_pass   = 0;
    int          n_total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (rom_we_o) begin
                log_adr.push_back(rom_adr_o);
                log_dat.push_back(rom_dat_o);
            end
            if (tx_stb_o) log_tx.push_back(tx_dat_o);
            if (wq.size() > 0 && wq[0].due == cyc) begin
                check("wr_strobe", rom_we_o, 1);
                check("wr_adr", rom_adr_o, wq[0].adr);
                check("wr_dat", rom_dat_o, wq[0].dat);
                void'(wq.pop_front());
            end else begin
                check("no_stray_write", rom_we_o, 0);
            end
            if (tq.size() > 0 && tq[0].due == cyc) begin
                check("tx_strobe", tx_stb_o, 1);
                check("tx_dat", tx_dat_o, tq[0].dat);
                void'(tq.pop_front());
            end else begin
                check("no_stray_tx", tx_stb_o, 0);
            end
            check("tx_while_busy", tx_stb_o & tx_busy_i, 0);
            check("cpu_reset", cpu_reset_o, exp_cpu);
            check("err", err_o, exp_err);
            check("busy", busy_o, exp_busy);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int extra, output int bc);
        repeat (extra) @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rx_dat_i = b;
        rx_stb_i = 1'b1;
        bc       = cyc;
        @(posedge clk_i);
        #1;
        rx_stb_i = 1'b0;
    endtask

    // Model of one whole frame held in fq: writes land one cycle after each
    // DAT_HI byte at base+k (mod 2^13), reply is ACK iff the byte sum after SYNC is 0.
    task automatic send_frame(input int hold);
        int         bc;
        int         cnt;
        int         base;
        logic [7:0] sum;
        bit         good;
        wr_t        w;
        tx_t        t;
        cnt  = int'({fq[2], fq[1]});
        base = int'({fq[4], fq[3]}) % 8192;
        sum  = 8'h00;
        for (int i = 1; i < fq.size(); i++) sum = sum + fq[i];
        good = (sum == 8'h00);
        send_byte(fq[0], 0, bc);
        exp_cpu  = 1'b1;
        exp_err  = 1'b0;
        exp_busy = 1'b1;
        for (int i = 1; i < fq.size(); i++) begin
            if (i == fq.size() - 1) tx_busy_i = (hold > 0);
            send_byte(fq[i], (i == gap_at) ? gap_len : 0, bc);
            if (i >= 6 && i <= 4 + 2 * cnt && (i % 2) == 0) begin
                w.due = bc + 1;
                w.adr = 13'((base + (i - 6) / 2) % 8192);
                w.dat = 14'({fq[i], fq[i-1]} & 16'h3FFF);
                wq.push_back(w);
            end
        end
        if (!good) exp_err = 1'b1;
        repeat (hold) begin
            @(posedge clk_i);
            #1;
        end
        tx_busy_i = 1'b0;
        t.due = cyc;
        t.dat = good ? 8'h06 : 8'h15;
        tq.push_back(t);
        if (good) exp_cpu = 1'b0;
        @(posedge clk_i);
        #1;
        exp_busy = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_dat"}, tx_dat_o, 0);
        check({tag, "_tx_stb"}, tx_stb_o, 0);
        check({tag, "_rom_adr"}, rom_adr_o, 0);
        check({tag, "_rom_dat"}, rom_dat_o, 0);
        check({tag, "_rom_we"}, rom_we_o, 0);
        check({tag, "_cpu_reset"}, cpu_reset_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int bc;
        int l0;
        int t0;
        #12;
        check_outputs_zero("reset");
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Two words at 0x0010, good checksum
        l0 = log_adr.size();
        t0 = log_tx.size();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h34, 8'h12, 8'hFF, 8'h3F, 8'h6A};
        send_frame(0);
        check("t1_nwrites", log_adr.size() - l0, 2);
        check("t1_adr0", log_adr[l0], 13'h0010);
        check("t1_dat0", log_dat[l0], 14'h1234);
        check("t1_adr1", log_adr[l0+1], 13'h0011);
        check("t1_dat1", log_dat[l0+1], 14'h3FFF);
        check("t1_tx", log_tx[t0], 8'h06);
        check("t1_cpu_reset", cpu_reset_o, 0);

        // Bad checksum: writes kept, NAK, error latched, CPU held
        l0 = log_adr.size();
        t0 = log_tx.size();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h34, 8'h12, 8'hFF, 8'h3F, 8'h7D};
        send_frame(0);
        check("t2_nwrites", log_adr.size() - l0, 2);
        check("t2_tx", log_tx[t0], 8'h15);
        check("t2_err", err_o, 1);
        check("t2_cpu_reset", cpu_reset_o, 1);

        // Good frame with the transmitter busy for 50 cycles at CSUM
        t0 = log_tx.size();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h34, 8'h12, 8'hFF, 8'h3F, 8'h6A};
        send_frame(50);
        repeat (3) @(posedge clk_i);
        #1;
        check("t5_tx_count", log_tx.size() - t0, 1);
        check("t5_tx", log_tx[t0], 8'h06);
        check("t5_err", err_o, 0);

        // Address wrap 0x1FFF -> 0x0000
        l0 = log_adr.size();
        fq = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'h1F, 8'h01, 8'h00, 8'h02, 8'h00, 8'hDD};
        send_frame(0);
        check("t3_adr0", log_adr[l0], 13'h1FFF);
        check("t3_dat0", log_dat[l0], 14'h0001);
        check("t3_adr1", log_adr[l0+1], 13'h0000);
        check("t3_dat1", log_dat[l0+1], 14'h0002);

        // Timeout after CNT: NAK after T idle cycles, later non-SYNC ignored
        t0 = log_tx.size();
        send_byte(8'hA5, 0, bc);
        exp_cpu  = 1'b1;
        exp_err  = 1'b0;
        exp_busy = 1'b1;
        send_byte(8'h01, 0, bc);
        send_byte(8'h00, 0, bc);
        begin
            tx_t t;
            t.due = bc + T + 1;
            t.dat = 8'h15;
            tq.push_back(t);
        end
        while (cyc < bc + T + 1) begin
            @(posedge clk_i);
            #1;
        end
        exp_err = 1'b1;
        @(posedge clk_i);
        #1;
        exp_busy = 1'b0;
        send_byte(8'h33, 0, bc);
        repeat (3) @(posedge clk_i);
        #1;
        check("t4_tx", log_tx[t0], 8'h15);
        check("t4_busy_after", busy_o, 0);
        check("t4_err", err_o, 1);

        // Byte on the terminal timeout cycle wins; high data bits dropped
        l0 = log_adr.size();
        t0 = log_tx.size();
        fq = '{8'hA5, 8'h01, 8'h00, 8'h40, 8'h00, 8'hFF, 8'hFF, 8'hC1};
        gap_at  = 3;
        gap_len = T - 2;
        send_frame(0);
        gap_at  = -1;
        check("tw_adr", log_adr[l0], 13'h0040);
        check("tw_dat", log_dat[l0], 14'h3FFF);
        check("tw_tx", log_tx[t0], 8'h06);

        // Noise then an empty frame
        l0 = log_adr.size();
        t0 = log_tx.size();
        send_byte(8'h00, 0, bc);
        send_byte(8'hFF, 0, bc);
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("t6_nwrites", log_adr.size() - l0, 0);
        check("t6_tx", log_tx[t0], 8'h06);

        // Asynchronous reset while waiting for DAT_LO
        send_byte(8'hA5, 0, bc);
        exp_cpu  = 1'b1;
        exp_err  = 1'b0;
        exp_busy = 1'b1;
        send_byte(8'h01, 0, bc);
        send_byte(8'h00, 0, bc);
        send_byte(8'h20, 0, bc);
        send_byte(8'h00, 0, bc);
        #2;
        reset_i  = 1'b1;
        exp_cpu  = 1'b0;
        exp_busy = 1'b0;
        #1;
        check_outputs_zero("arst");
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Recovery after reset
        t0 = log_tx.size();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h34, 8'h12, 8'hFF, 8'h3F, 8'h6A};
        send_frame(0);
        check("rec_tx", log_tx[t0], 8'h06);

        repeat (3) @(posedge clk_i);
        #1;
        check("writes_drained", wq.size(), 0);
        check("replies_drained", tq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
